// File: rtl/lbl_collector.sv
// lbl_collector: gathers K_NUM labels one at a time from a valid/ready stream
// and presents them together as one group on outL. A group closed early by
// in_last is dropped, and err pulses for one cycle. outL stays frozen until
// the downstream consumer takes the group.
module lbl_collector #(
  parameter int LBL_LEN = 10,
  parameter int K_NUM   = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LBL_LEN-1:0]           in_lbl,
  input  logic                         in_last,
  output logic [LBL_LEN-1:0]           outL [K_NUM-1:0],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(K_NUM+1)-1:0]   fill_cnt,
  output logic                         err
);

  localparam int CNT_W = $clog2(K_NUM + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(K_NUM - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(K_NUM);

  typedef enum logic {ST_FILL, ST_FULL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic               err_q, err_d;
  logic [LBL_LEN-1:0] lbl_q [K_NUM-1:0];

  logic xfer;       // a label is handed over this cycle
  logic last_slot;  // this transfer would store the K_NUM-th label
  logic short_grp;  // in_last arrived before the group was complete
  logic wr_en;      // the incoming label is kept

  assign xfer      = in_valid && in_ready;
  assign last_slot = (fill_cnt_q == LAST_IDX);
  assign short_grp = xfer && in_last && !last_slot;
  assign wr_en     = xfer && !short_grp;

  // State, count and error pulse registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FILL;
      fill_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: FILL counts labels up to K_NUM, FULL waits for release.
  // NOTE: every signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    err_d      = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (xfer) begin
          if (last_slot) begin
            state_d    = ST_FULL;
            fill_cnt_d = FULL_CNT;
          end else if (in_last) begin
            fill_cnt_d = '0;
            err_d      = 1'b1;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          state_d    = ST_FILL;
          fill_cnt_d = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Output decode: handshake flags follow the state directly.
  always_comb begin
    in_ready  = (state_q == ST_FILL);
    out_valid = (state_q == ST_FULL);
  end

  // Label storage: the accepted label lands in the slot selected by fill_cnt.
  // NOTE: the label array is reset here because consumers expect all-zero
  // labels after reset; it is not left to power-up contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K_NUM; i++) lbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < K_NUM; i++) begin
        if (wr_en && (fill_cnt_q == CNT_W'(i))) lbl_q[i] <= in_lbl;
      end
    end
  end

  assign outL     = lbl_q;
  assign fill_cnt = fill_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_lbl_collector.sv
// tb_lbl_collector: directed stimulus for lbl_collector (K_NUM=5, LBL_LEN=10).
// A group-level model runs alongside the DUT and is compared against it on
// every falling edge. Literal checks inside the stimulus pin the model to
// hand-computed values.
module tb_lbl_collector;

  localparam int LBL_LEN = 10;
  localparam int K_NUM   = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [LBL_LEN-1:0] in_lbl = '0;
  logic               in_last = 1'b0;
  logic [LBL_LEN-1:0] out_l [K_NUM-1:0];
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [2:0]         fill_cnt;
  logic               err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  lbl_collector #(.LBL_LEN(LBL_LEN), .K_NUM(K_NUM)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_lbl   (in_lbl),
    .in_last  (in_last),
    .outL     (out_l),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fill_cnt (fill_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Group-level model. The group is either being collected (m_full = 0,
  // m_cnt labels so far) or complete and waiting for the consumer.
  logic [LBL_LEN-1:0] m_lbl [K_NUM];
  int m_cnt  = 0;
  bit m_full = 1'b0;
  bit m_err  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K_NUM; i++) m_lbl[i] = '0;
      m_cnt  = 0;
      m_full = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_full) begin
        if (out_ready) begin
          m_full = 1'b0;
          m_cnt  = 0;
        end
      end else if (in_valid) begin
        if (m_cnt + 1 == K_NUM) begin
          m_lbl[m_cnt] = in_lbl;
          m_cnt  = K_NUM;
          m_full = 1'b1;
        end else if (in_last) begin
          m_cnt = 0;
          m_err = 1'b1;
        end else begin
          m_lbl[m_cnt] = in_lbl;
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  32'(in_ready),  32'(!m_full));
      check("out_valid", 32'(out_valid), 32'(m_full));
      check("fill_cnt",  32'(fill_cnt),  32'(m_cnt));
      check("err",       32'(err),       32'(m_err));
      for (int i = 0; i < K_NUM; i++) check($sformatf("outL[%0d]", i), 32'(out_l[i]), 32'(m_lbl[i]));
    end
  end

  // One clock of stimulus; returns 1 time unit after the rising edge.
  task automatic drive(input bit v, input logic [LBL_LEN-1:0] l, input bit last,
                       input bit ordy, input bit r = 1'b0);
    in_valid  = v;
    in_lbl    = l;
    in_last   = last;
    out_ready = ordy;
    rst       = r;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [LBL_LEN-1:0] vec_a [K_NUM];
  logic [LBL_LEN-1:0] vec_b [K_NUM];
  logic [LBL_LEN-1:0] vec_c [K_NUM];

  initial begin
    vec_a = '{10'h021, 10'h042, 10'h063, 10'h084, 10'h0A5};
    vec_b = '{10'h101, 10'h102, 10'h103, 10'h104, 10'h105};
    vec_c = '{10'h3C1, 10'h2B2, 10'h1A3, 10'h094, 10'h385};

    // Reset
    drive(0, '0, 0, 0, 1);
    drive(0, '0, 0, 0, 1);
    chk_en = 1'b1;
    check("rst in_ready",  32'(in_ready),  32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst fill_cnt",  32'(fill_cnt),  32'd0);
    check("rst outL0",     32'(out_l[0]),  32'd0);

    // Back-to-back fill with out_ready high
    for (int i = 0; i < K_NUM; i++) drive(1, vec_a[i], 0, 1);
    check("b2b out_valid", 32'(out_valid), 32'd1);
    check("b2b fill_cnt",  32'(fill_cnt),  32'd5);
    for (int i = 0; i < K_NUM; i++) check($sformatf("b2b outL%0d", i), 32'(out_l[i]), 32'(vec_a[i]));
    drive(1, 10'h3FF, 0, 1);  // release edge: no transfer
    check("b2b rel in_ready", 32'(in_ready), 32'd1);
    check("b2b rel fill_cnt", 32'(fill_cnt), 32'd0);

    // Backpressure
    for (int i = 0; i < K_NUM; i++) drive(1, vec_b[i], 0, 0);
    for (int c = 0; c < 10; c++) begin
      drive(1, 10'h3FF, 0, 0);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp fill_cnt", 32'(fill_cnt), 32'd5);
      check("bp outL4",    32'(out_l[4]), 32'h105);
    end
    drive(1, 10'h155, 0, 1);  // released, label not taken
    check("bp rel fill_cnt", 32'(fill_cnt), 32'd0);
    check("bp rel outL0",    32'(out_l[0]), 32'h101);
    drive(1, 10'h155, 0, 0);  // accepted one cycle later
    check("bp next fill_cnt", 32'(fill_cnt), 32'd1);
    check("bp next outL0",    32'(out_l[0]), 32'h155);
    drive(0, '0, 0, 0, 1);

    // Short group: three labels, last on the third
    drive(1, 10'h011, 0, 0);
    drive(1, 10'h012, 0, 0);
    drive(1, 10'h013, 1, 0);
    check("short err",       32'(err),       32'd1);
    check("short fill_cnt",  32'(fill_cnt),  32'd0);
    check("short out_valid", 32'(out_valid), 32'd0);
    check("short outL2",     32'(out_l[2]),  32'd0);
    drive(0, '0, 0, 0);
    check("short err drop",  32'(err),       32'd0);
    for (int i = 0; i < K_NUM; i++) drive(1, vec_c[i], (i == K_NUM - 1), 0);
    check("after short out_valid", 32'(out_valid), 32'd1);
    check("after short outL0",     32'(out_l[0]),  32'h3C1);
    check("after short err",       32'(err),       32'd0);
    drive(0, '0, 0, 1);

    // Gaps: valid toggles over 12 cycles, 5 labels delivered
    for (int c = 0; c < 12; c++) begin
      if (c % 2 == 0) drive(1, vec_a[(c / 2) % K_NUM] ^ 10'h200, 0, 0);
      else            drive(0, 10'h3FF, 0, 0);
    end
    check("gap out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < K_NUM; i++) check($sformatf("gap outL%0d", i), 32'(out_l[i]), 32'(vec_a[i] ^ 10'h200));
    drive(0, '0, 0, 1);

    // Reset after two transfers, with a transfer coinciding with reset
    drive(1, 10'h0F1, 0, 0);
    drive(1, 10'h0F2, 0, 0);
    drive(1, 10'h0F3, 1, 0, 1);
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    check("mid rst fill_cnt", 32'(fill_cnt), 32'd0);
    check("mid rst err",      32'(err),      32'd0);
    check("mid rst outL0",    32'(out_l[0]), 32'd0);
    drive(0, '0, 0, 0);
    check("mid rst err2",     32'(err),      32'd0);

    // Reset while holding a full group
    for (int i = 0; i < K_NUM; i++) drive(1, vec_b[i], 0, 0);
    check("full pre-rst out_valid", 32'(out_valid), 32'd1);
    drive(1, 10'h2AA, 0, 0, 1);
    check("full rst out_valid", 32'(out_valid), 32'd0);
    check("full rst in_ready",  32'(in_ready),  32'd1);
    check("full rst outL3",     32'(out_l[3]),  32'd0);
    drive(1, 10'h2AA, 0, 0);
    check("full rst err",       32'(err),       32'd0);
    check("full rst accept",    32'(out_l[0]),  32'h2AA);

    drive(0, '0, 0, 0);
    drive(0, '0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lbl_collector.md
LBL_COLLECTOR -- requirements
Module: lbl_collector

Interface
REQ-001 The module SHALL have parameter LBL_LEN, default 10, giving the label width in bits; the upper LBL_LEN/2 bits are X and the lower LBL_LEN/2 bits are Y, and the block does not interpret them.
REQ-002 The module SHALL have parameter K_NUM, default 5, giving the number of labels per group (the K nearest neighbours).
REQ-003 The module SHALL have port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, width 1; reset is synchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, width 1, meaning the upstream label is valid.
REQ-006 The module SHALL have port in_ready, output, width 1, meaning the collector can accept a label.
REQ-007 The module SHALL have port in_lbl, input, width LBL_LEN, carrying the label data.
REQ-008 The module SHALL have port in_last, input, width 1, marking the final label of the current group; it is sampled only on a transfer.
REQ-009 The module SHALL have port outL, output, unpacked array [K_NUM-1:0] of width LBL_LEN, holding the collected labels in parallel; it is the direct feed to the averaging block's label inputs.
REQ-010 The module SHALL have port out_valid, output, width 1, meaning outL holds a complete group.
REQ-011 The module SHALL have port out_ready, input, width 1, meaning the downstream consumer takes the group.
REQ-012 The module SHALL have port fill_cnt, output, width $clog2(K_NUM+1), giving the number of labels stored in the current group.
REQ-013 The module SHALL have port err, output, width 1, a one-cycle pulse flagging a short group.

Function
REQ-014 The block SHALL implement exactly two states: FILL and FULL.
REQ-015 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 In FULL, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 A transfer SHALL occur when in_valid and in_ready are both 1 in the same cycle; no label is taken otherwise.
REQ-018 On a transfer in FILL, in_lbl SHALL be written into outL[fill_cnt] and fill_cnt SHALL increment by 1.
REQ-019 When the transfer stores the K_NUM-th label (fill_cnt = K_NUM-1 before the edge), the state SHALL become FULL, fill_cnt SHALL become K_NUM, and out_valid SHALL be 1 in the next cycle (latency 1 cycle); this happens regardless of in_last.
REQ-020 When a transfer has in_last = 1 and fill_cnt+1 < K_NUM (a short group), the label SHALL be discarded, fill_cnt SHALL return to 0, the state SHALL stay FILL, and err SHALL be 1 for exactly the next cycle.
REQ-021 A short group SHALL leave outL entries unchanged except those already written during the aborted group.
REQ-022 In FULL, outL SHALL remain stable until the group is released.
REQ-023 When out_valid and out_ready are both 1, the state SHALL return to FILL and fill_cnt SHALL become 0 at that edge.
REQ-024 No label SHALL be accepted in the cycle the group is released; the earliest next transfer is the following cycle.
REQ-025 While out_ready = 0 in FULL, the block SHALL wait indefinitely with all outputs held.
REQ-026 outL entries at indices >= fill_cnt SHALL keep their previous values and are don't-care to consumers while out_valid = 0.
REQ-027 fill_cnt SHALL never exceed K_NUM.
REQ-028 err SHALL be 0 in every cycle except the one following a short-group abort.

Reset
REQ-029 While rst = 1 at a clock edge, the state SHALL become FILL, fill_cnt SHALL become 0, every outL entry SHALL become 0, out_valid SHALL become 0, and err SHALL become 0.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-031 Reset asserted in mid-group or in FULL SHALL drop the partial or held group without asserting err.
REQ-032 Any transfer coinciding with rst = 1 SHALL be ignored.

Verification
REQ-033 With K_NUM = 5 and LBL_LEN = 10, the bench SHALL cover a back-to-back fill: labels 0x021, 0x042, 0x063, 0x084, 0x0A5 with in_valid held high and out_ready = 1 -> out_valid = 1 exactly one cycle after the 5th transfer, outL[0..4] equal to the inputs in order, then FILL on the next edge.
REQ-034 The bench SHALL cover backpressure: a full group with out_ready = 0 for 10 cycles while in_valid = 1 -> in_ready = 0 throughout, outL stable, fill_cnt = 5; when out_ready rises to 1, the group releases and the next label is accepted one cycle later.
REQ-035 The bench SHALL cover a short group: 3 labels with in_last = 1 on the 3rd -> err = 1 for one cycle, fill_cnt = 0, out_valid never rises; a following full 5-label group completes normally.
REQ-036 The bench SHALL cover gaps in input: in_valid toggled 1-0-1 across 12 cycles delivering 5 labels -> only asserted-valid labels are stored and out_valid rises after the 5th.
REQ-037 The bench SHALL cover reset mid-operation: rst pulsed for 1 cycle after 2 transfers, and again while in FULL -> all outputs reset to 0, err stays 0, and in_ready = 1 in the next cycle.
